// File: rtl/corexy_pkg.sv
// Shared constants for the CoreXY move planner: FSM encoding, default sizes, helpers.
package corexy_pkg;

  localparam int unsigned DIV_W     = 48;
  localparam int unsigned COORD_MAX = 32'h1FFF_FFFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_DIV   = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Magnitude as unsigned; -2^31 maps to 2^31, which is out of range anyway.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/corexy_div.sv
// Sequential restoring divider: one quotient bit per cycle, DIV_W cycles per division.
module corexy_div #(
  parameter int unsigned DIV_W = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [31:0]      divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DIV_W);

  logic [31:0]      rem;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [31:0]      rem_src;
  logic [DIV_W-1:0] quo_src;
  logic [32:0]      trial;
  logic [31:0]      rem_next;
  logic [DIV_W-1:0] quo_next;
  logic             q_bit;

  // The start cycle already performs the first iteration, so the whole
  // division occupies exactly DIV_W clock edges.
  always_comb begin
    rem_src = start ? '0 : rem;
    quo_src = start ? dividend : quotient;
    trial   = {rem_src, quo_src[DIV_W-1]};
    q_bit   = (trial >= {1'b0, divisor});
    rem_next = q_bit ? 32'(trial - {1'b0, divisor}) : trial[31:0];
    quo_next = {quo_src[DIV_W-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_next;
        quotient <= quo_next;
        cnt      <= CNT_W'(DIV_W - 1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_next;
        quotient <= quo_next;
        cnt      <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/move_planner_corexy.sv
// CoreXY move planner: converts an X/Y delta into A/B motor step counts and speeds.
module move_planner_corexy #(
  parameter int unsigned DIV_W     = corexy_pkg::DIV_W,
  parameter int unsigned COORD_MAX = corexy_pkg::COORD_MAX
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_dx,
  input  logic [31:0] cmd_dy,
  input  logic [15:0] cmd_period,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] stepper_step_a,
  output logic [31:0] stepper_step_b,
  output logic [31:0] stepper_speed_a,
  output logic [31:0] stepper_speed_b,
  output logic        start_driving,
  input  logic        steppers_driving,
  output logic        move_done,
  output logic        cmd_error
);

  import corexy_pkg::ST_IDLE, corexy_pkg::ST_CALC, corexy_pkg::ST_DIV;
  import corexy_pkg::ST_START, corexy_pkg::ST_RUN, corexy_pkg::ST_DONE;
  import corexy_pkg::abs32;

  logic [2:0]        state;
  logic signed [31:0] dx_r, dy_r;
  logic [15:0]       period_r;
  logic signed [31:0] a_r, b_r;
  logic              a_dom_r, na_zero_r, nb_zero_r;
  logic [DIV_W-1:0]  prod_r;
  logic [31:0]       nmin_r;
  logic              div_go;
  logic              div_done;
  logic [DIV_W-1:0]  quotient;

  logic signed [31:0] sum, diff;
  logic [31:0]       na, nb, nmaj, nmin;
  logic              a_dom, range_err, zero_move;
  logic [47:0]       product;
  logic [31:0]       speed_minor, period32;

  always_comb begin
    sum       = dx_r + dy_r;
    diff      = dx_r - dy_r;
    na        = abs32(sum);
    nb        = abs32(diff);
    a_dom     = (na >= nb);
    nmaj      = a_dom ? na : nb;
    nmin      = a_dom ? nb : na;
    range_err = (abs32(dx_r) > COORD_MAX) || (abs32(dy_r) > COORD_MAX);
    zero_move = (na == '0) && (nb == '0);
    product   = 48'(period_r) * 48'(nmaj);
    period32  = {16'd0, period_r};
    speed_minor = (|quotient[DIV_W-1:32]) ? '1 : quotient[31:0];
  end

  corexy_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_go),
    .dividend (prod_r),
    .divisor  (nmin_r),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      dx_r            <= '0;
      dy_r            <= '0;
      period_r        <= '0;
      a_r             <= '0;
      b_r             <= '0;
      a_dom_r         <= 1'b0;
      na_zero_r       <= 1'b0;
      nb_zero_r       <= 1'b0;
      prod_r          <= '0;
      nmin_r          <= '0;
      div_go          <= 1'b0;
      stepper_step_a  <= '0;
      stepper_step_b  <= '0;
      stepper_speed_a <= '0;
      stepper_speed_b <= '0;
    end else begin
      div_go <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          dx_r     <= cmd_dx;
          dy_r     <= cmd_dy;
          period_r <= (cmd_period == '0) ? 16'd1 : cmd_period;
          state    <= ST_CALC;
        end
        ST_CALC: begin
          if (range_err)      state <= ST_IDLE;
          else if (zero_move) state <= ST_DONE;
          else begin
            a_r       <= sum;
            b_r       <= diff;
            a_dom_r   <= a_dom;
            na_zero_r <= (na == '0);
            nb_zero_r <= (nb == '0);
            prod_r    <= DIV_W'(product);
            nmin_r    <= nmin;
            div_go    <= 1'b1;
            state     <= ST_DIV;
          end
        end
        // Divide-by-zero yields all ones; a zero-step motor is overridden to period.
        ST_DIV: if (div_done) begin
          stepper_step_a  <= a_r;
          stepper_step_b  <= b_r;
          if (a_dom_r) begin
            stepper_speed_a <= period32;
            stepper_speed_b <= nb_zero_r ? period32 : speed_minor;
          end else begin
            stepper_speed_b <= period32;
            stepper_speed_a <= na_zero_r ? period32 : speed_minor;
          end
          state <= ST_START;
        end
        ST_START: if (steppers_driving)  state <= ST_RUN;
        ST_RUN:   if (!steppers_driving) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state == ST_IDLE) && reset_n;
  assign start_driving = (state == ST_START);
  assign move_done     = (state == ST_DONE);
  assign cmd_error     = (state == ST_CALC) && range_err;

endmodule

// File: tb/tb_move_planner_corexy.sv
// Directed bench for move_planner_corexy with hand-computed expected values.
module tb_move_planner_corexy;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cmd_dx = '0, cmd_dy = '0;
  logic [15:0] cmd_period = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] stepper_step_a, stepper_step_b, stepper_speed_a, stepper_speed_b;
  logic        start_driving;
  logic        steppers_driving = 1'b0;
  logic        move_done, cmd_error;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  move_planner_corexy #(.DIV_W(48), .COORD_MAX(32'h1FFF_FFFF)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_dx           (cmd_dx),
    .cmd_dy           (cmd_dy),
    .cmd_period       (cmd_period),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .stepper_step_a   (stepper_step_a),
    .stepper_step_b   (stepper_step_b),
    .stepper_speed_a  (stepper_speed_a),
    .stepper_speed_b  (stepper_speed_b),
    .start_driving    (start_driving),
    .steppers_driving (steppers_driving),
    .move_done        (move_done),
    .cmd_error        (cmd_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents a command and returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] dx, input logic [31:0] dy, input logic [15:0] p);
    @(negedge clk);
    cmd_dx = dx; cmd_dy = dy; cmd_period = p; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int unsigned n = 0;
    while (start_driving !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":lat"}, 64'(n), 64'd50);
  endtask

  task automatic do_move(input string tag, input logic [31:0] dx, input logic [31:0] dy,
                         input logic [15:0] p, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] va, input logic [31:0] vb);
    send(dx, dy, p);
    check({tag, ":busy"}, 64'(cmd_ready), 64'd0);
    wait_start(tag);
    check({tag, ":step_a"}, 64'(stepper_step_a), 64'(ea));
    check({tag, ":step_b"}, 64'(stepper_step_b), 64'(eb));
    check({tag, ":speed_a"}, 64'(stepper_speed_a), 64'(va));
    check({tag, ":speed_b"}, 64'(stepper_speed_b), 64'(vb));
    repeat (3) @(posedge clk);
    #1 check({tag, ":hold"}, 64'(start_driving), 64'd1);
    @(negedge clk) steppers_driving = 1'b1;
    @(posedge clk); #1;
    check({tag, ":run"}, 64'(start_driving), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) steppers_driving = 1'b0;
    @(posedge clk); #1;
    check({tag, ":done"}, 64'(move_done), 64'd1);
    @(posedge clk); #1;
    check({tag, ":done_off"}, 64'(move_done), 64'd0);
    check({tag, ":ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst:start", 64'(start_driving), 64'd0);
    check("rst:done", 64'(move_done), 64'd0);
    check("rst:err", 64'(cmd_error), 64'd0);
    check("rst:step_a", 64'(stepper_step_a), 64'd0);
    check("rst:speed_b", 64'(stepper_speed_b), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    #1 check("rst:ready", 64'(cmd_ready), 64'd1);

    do_move("x100",  32'd100, 32'd0,  16'd10, 32'd100, 32'd100, 32'd10, 32'd10);
    do_move("x100y50", 32'd100, 32'd50, 16'd10, 32'd150, 32'd50, 32'd10, 32'd30);
    do_move("floor", 32'd5, 32'd2, 16'd7, 32'd7, 32'd3, 32'd7, 32'd16);
    do_move("neg_a", 32'hFFFF_FFE2, 32'hFFFF_FFF6, 16'd4,
            32'hFFFF_FFD8, 32'hFFFF_FFEC, 32'd4, 32'd8);
    do_move("bdom", 32'd10, 32'hFFFF_FFE2, 16'd3, 32'hFFFF_FFEC, 32'd40, 32'd6, 32'd3);
    do_move("p0", 32'd3, 32'd1, 16'd0, 32'd4, 32'd2, 32'd1, 32'd2);
    do_move("sat", 32'h1FFF_FFFF, 32'h1FFF_FFFE, 16'hFFFF,
            32'h3FFF_FFFD, 32'd1, 32'h0000_FFFF, 32'hFFFF_FFFF);
    do_move("diag", 32'hFFFF_FFD8, 32'd40, 16'd10, 32'd0, 32'hFFFF_FFB0, 32'd10, 32'd10);

    // Zero move: retires without driving.
    send(32'd0, 32'd0, 16'd10);
    check("zero:calc_done", 64'(move_done), 64'd0);
    @(posedge clk); #1;
    check("zero:done", 64'(move_done), 64'd1);
    check("zero:nostart", 64'(start_driving), 64'd0);
    @(posedge clk); #1;
    check("zero:done_off", 64'(move_done), 64'd0);
    check("zero:ready", 64'(cmd_ready), 64'd1);
    check("zero:keep_b", 64'(stepper_step_b), 64'hFFFF_FFB0);

    // Out-of-range commands are rejected and leave outputs untouched.
    send(32'h2000_0000, 32'd0, 16'd10);
    check("err:pulse", 64'(cmd_error), 64'd1);
    @(posedge clk); #1;
    check("err:off", 64'(cmd_error), 64'd0);
    check("err:ready", 64'(cmd_ready), 64'd1);
    check("err:keep_b", 64'(stepper_step_b), 64'hFFFF_FFB0);
    check("err:keep_va", 64'(stepper_speed_a), 64'd10);
    send(32'd1, 32'hE000_0000, 16'd10);
    check("err2:pulse", 64'(cmd_error), 64'd1);
    @(posedge clk); #1;
    check("err2:nostart", 64'(start_driving), 64'd0);

    // Reset while in START drops start_driving at once.
    send(32'd100, 32'd50, 16'd10);
    wait_start("rst_start");
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_start:drive", 64'(start_driving), 64'd0);
    check("rst_start:step_a", 64'(stepper_step_a), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    #1 check("rst_start:ready", 64'(cmd_ready), 64'd1);

    // Reset while in RUN.
    send(32'd100, 32'd0, 16'd10);
    wait_start("rst_run");
    @(negedge clk) steppers_driving = 1'b1;
    @(posedge clk); #1;
    check("rst_run:run", 64'(start_driving), 64'd0);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("rst_run:drive", 64'(start_driving), 64'd0);
    check("rst_run:speed_b", 64'(stepper_speed_b), 64'd0);
    steppers_driving = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    #1 check("rst_run:ready", 64'(cmd_ready), 64'd1);

    // Reset mid-division, then a full move must keep exact timing and result.
    send(32'd100, 32'd50, 16'd10);
    repeat (10) @(posedge clk);
    pulse_reset();
    #1 check("rst_div:ready", 64'(cmd_ready), 64'd1);
    do_move("after_rst", 32'd5, 32'd2, 16'd7, 32'd7, 32'd3, 32'd7, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_planner_corexy.md
MOVE_PLANNER_COREXY -- requirements
Module: move_planner_corexy

Interface
REQ-001 SHALL have parameter DIV_W, default 48, dividend width of the speed divider.
REQ-002 SHALL have parameter COORD_MAX, default 2^29-1, largest accepted |cmd_dx| or |cmd_dy|.
REQ-003 SHALL have ports clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have ports reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have ports cmd_dx, input, 32, signed two's-complement X delta in steps.
REQ-006 SHALL have ports cmd_dy, input, 32, signed two's-complement Y delta in steps.
REQ-007 SHALL have ports cmd_period, input, 16, half-step period in clk cycles for the dominant motor.
REQ-008 SHALL have ports cmd_valid, input, 1, and cmd_ready, output, 1, as the command handshake.
REQ-009 SHALL have ports stepper_step_a, output, 32, and stepper_step_b, output, 32, signed motor A/B step counts.
REQ-010 SHALL have ports stepper_speed_a, output, 32, and stepper_speed_b, output, 32, half-period per motor.
REQ-011 SHALL have ports start_driving, output, 1, move request to the stepper stage.
REQ-012 SHALL have ports steppers_driving, input, 1, busy flag from the stepper stage.
REQ-013 SHALL have ports move_done, output, 1, one-cycle pulse per retired command.
REQ-014 SHALL have ports cmd_error, output, 1, one-cycle pulse per rejected command.

Function
REQ-015 SHALL accept a command on a clk edge with cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in IDLE.
REQ-016 SHALL run FSM states IDLE, CALC, DIV, START, RUN, DONE.
REQ-017 IDLE->CALC on accept: latch dx, dy, period; period 0 SHALL be treated as 1.
REQ-018 CALC, 1 cycle: a=dx+dy, b=dx-dy as 32-bit signed; Na=|a|, Nb=|b|; Nmaj=max, Nmin=min.
REQ-019 CALC: |dx|>COORD_MAX or |dy|>COORD_MAX -> pulse cmd_error, no outputs change, go to IDLE.
REQ-020 CALC: Na=Nb=0 -> go to DONE, no start_driving.
REQ-021 DIV SHALL always last exactly DIV_W cycles, regardless of operands.
REQ-022 Dominant motor speed = period; minor motor speed = floor(period*Nmaj/Nmin).
REQ-023 Quotient above 2^32-1 SHALL saturate to 0xFFFF_FFFF; a motor with N=0 gets speed=period; Na=Nb gives both speed=period.
REQ-024 stepper_step_a/b and stepper_speed_a/b SHALL update on entry to START and hold until the next START.
REQ-025 START: start_driving=1; first edge sampling steppers_driving=1 -> RUN.
REQ-026 RUN: start_driving=0; first edge sampling steppers_driving=0 -> DONE.
REQ-027 An early stop by the stepper stage (endstop) SHALL be handled as normal completion.
REQ-028 DONE, 1 cycle: move_done=1, then IDLE.
REQ-029 start_driving SHALL rise exactly DIV_W+2 edges after the accepting edge.
REQ-030 start_driving SHALL be low for at least one cycle between moves so the stepper stage rearms.

Reset
REQ-031 reset_n=0 SHALL force, asynchronously, IDLE with all outputs 0 except cmd_ready=1 after release.
REQ-032 Reset mid-move SHALL drop start_driving immediately and discard the latched command.
REQ-033 Reset SHALL abort any in-progress division.

Structure
REQ-034 FSM state encoding, DIV_W, and COORD_MAX SHALL live in package corexy_pkg.
REQ-035 SHALL instantiate one sub-module, corexy_div: sequential restoring divider, DIV_W-bit dividend, 32-bit divisor, start/done handshake.
REQ-036 The 16x30 product SHALL be formed combinationally in CALC and registered.

Verification
REQ-037 dx=100, dy=0, P=10 -> step_a=100, step_b=100, speeds 10/10; start at edge 50; move_done after driving falls.
REQ-038 dx=100, dy=50, P=10 -> step_a=150, step_b=50, speed_a=10, speed_b=30.
REQ-039 dx=-40, dy=40, P=10 -> step_a=0, step_b=0xFFFFFFB0, speed_a=10, speed_b=10.
REQ-040 dx=0, dy=0 -> no start_driving, move_done 2 cycles after accept; dx=2^29 -> cmd_error, outputs unchanged.
REQ-041 Hold steppers_driving low after start -> FSM stays START; reset_n low in RUN -> start_driving 0 same cycle, cmd_ready 1 after release.
